inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the immediate generator and decoder.
- Holds the PC and issues one instruction-memory read at a time, tolerating variable memory latency.
- Presents fetched instruction + PC in an IF/ID output register (if_inst feeds ImmGen's inst input).
- Supports downstream stall (with one-entry skid buffer) and redirect/flush from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  one-cycle read request pulse; memory always accepts
imem_addr  output  32  read address, valid when imem_req=1
imem_rdata  input  32  read data, valid when imem_valid=1
imem_valid  input  1  response strobe, ≥1 cycle after imem_req, exactly one per request
stall  input  1  ID cannot accept; hold output register
redirect  input  1  flush + change PC (taken branch/jump)
redirect_pc  input  32  new fetch address when redirect=1
if_valid  output  1  output register holds a live instruction
if_inst  output  32  fetched instruction
if_pc  output  32  address of if_inst
fetch_misalign  output  1  see Optional Feature; tied 0 when compiled out

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=REQ, if_valid=0, if_inst=32'h0000_0013 (NOP), if_pc=0, skid empty, imem_req=0, imem_addr=0, fetch_misalign=0. The memory shares rst; any in-flight response is aborted.
- At most one outstanding request. imem_req/imem_addr are combinational from state: imem_req=1 only in REQ, imem_addr=pc.
- Consume rule: ID takes the output register in any cycle where if_valid=1 and stall=0.
- States:
  - REQ: assert imem_req for one cycle, go to WAIT.
  - WAIT, imem_valid=1:
    - If the output register is free (if_valid=0 or stall=0): load if_inst=imem_rdata, if_pc=pc, if_valid=1; pc+=4; go to REQ.
    - Else: write the skid register with {imem_rdata, pc}; go to HOLD.
  - WAIT, no imem_valid: if the output is consumed this cycle, clear if_valid.
  - HOLD: when stall=0, move skid to output (if_valid stays 1), pc+=4, go to REQ.
  - DROP: an outstanding response must be discarded. On imem_valid, discard data and go to REQ.
- Redirect has highest priority, overriding stall and any response in the same cycle:
  - if_valid=0, skid cleared, pc=redirect_pc.
  - Next state: DROP if in WAIT/DROP with imem_valid=0 this cycle; otherwise REQ.
  - Redirect in DROP updates pc and stays in DROP.
- Throughput: with 1-cycle memory, one instruction every 2 cycles. First imem_req occurs in the first cycle after rst deasserts.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Simultaneous stall=1 with an empty output: the instruction loads normally (stall only blocks draining).
- if_valid is never set while skid is full and the output is empty.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 and state enters DROP/REQ as normal, but REQ issues no request and holds.
  - fetch_misalign stays set (no fetch, if_valid=0) until the next aligned redirect or rst clears it.
- Undefined: redirect_pc[1:0] forced to 2'b00; fetch_misalign tied 0.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 at 0, 32'h00A00113 at 4, stall=0 → imem_addr 0, 4, 8 on cycles 1, 3, 5; if_inst=00500093/if_pc=0 valid from cycle 3, then 00A00113/4.
- 4-cycle latency memory → imem_req exactly once per 5 cycles, never two outstanding; if_pc increments by 4 per instruction.
- stall=1 held 6 cycles while two responses arrive → first stays on output, second in skid, no further imem_req; on stall=0 outputs drain in order with PCs 0 then 4, then fetch resumes at 8.
- redirect=1, redirect_pc=32'h100 while in WAIT (latency 3) → if_valid=0 next cycle, stale response discarded, next imem_addr=32'h100, if_pc=32'h100.
- redirect to 32'hFFFF_FFFC → fetches FFFF_FFFC then 0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h102 → fetch_misalign=1, no imem_req; redirect to 32'h200 → flag clears, fetch at 32'h200.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory read at a
// time and presents {inst, pc} to decode through an IF/ID register backed by a
// one-entry skid buffer. A redirect flushes the stage and restarts fetch.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect target raises fetch_misalign and parks fetch. When it is
// undefined, the low two bits of the redirect target are forced to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | issue a read at pc (held off while a misaligned target is parked)
// WAIT  | read outstanding; route response to output register or skid
// HOLD  | skid full, output blocked by stall; drain when stall drops
// DROP  | outstanding response belongs to a flushed path; discard it
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        fetch_misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] redir_target;
    logic        misalign_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_d;
    assign redir_target = redirect_pc;

    // Misalign flag: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
`else
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc[1:0];
    assign redir_target       = {redirect_pc[31:2], 2'b00};
    assign misalign_q         = 1'b0;
`endif

    // A request in the same cycle as a redirect (or during reset) would leave
    // an orphan response after the flush, so it is suppressed.
    assign imem_req       = (state_q == S_REQ) && !misalign_q && !redirect && !rst;
    assign imem_addr      = imem_req ? pc_q : 32'h0;
    assign if_valid       = if_valid_q;
    assign if_inst        = if_inst_q;
    assign if_pc          = if_pc_q;
    assign fetch_misalign = misalign_q;

    // State, PC, output register and skid buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_inst_q    <= NOP;
            if_pc_q      <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_valid_q   <= if_valid_d;
            if_inst_q    <= if_inst_d;
            if_pc_q      <= if_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Next-state: response routing, skid drain, consume, then redirect override.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_valid_d   = if_valid_q;
        if_inst_d    = if_inst_q;
        if_pc_d      = if_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d   = misalign_q;
`endif

        if (if_valid_q && !stall) if_valid_d = 1'b0;

        case (state_q)
            S_REQ: begin
                if (!misalign_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    if (!if_valid_q || !stall) begin
                        if_inst_d  = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_REQ;
                    end else begin
                        skid_inst_d  = imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall && skid_valid_q) begin
                    if_inst_d    = skid_inst_q;
                    if_pc_d      = skid_pc_q;
                    if_valid_d   = 1'b1;
                    skid_valid_d = 1'b0;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = redir_target;
            state_d      = ((state_q == S_WAIT || state_q == S_DROP) && !imem_valid)
                           ? S_DROP : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_d   = |redirect_pc[1:0];
`endif
        end
    end

endmodule
